// File: rtl/gf_pow_seq.sv
// Sequential GF(2^M) exponentiator: left-to-right square-and-multiply, one exponent bit per cycle.
// Inverse mode raises x to 2^M-2, which is x^-1 for nonzero x and 0 for x=0.
`timescale 1ns/1ps
module gf_pow_seq #(
  parameter int unsigned M    = 6,
  parameter logic [M:0]  POLY = 7'b1000011,
  parameter int unsigned EW   = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [M-1:0]  x,
  input  logic [EW-1:0] e,
  input  logic          inv,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [M-1:0]  y,
  output logic          busy
);

  localparam int unsigned XW = (EW > M) ? EW : M;
  localparam int unsigned CW = (XW > 1) ? $clog2(XW) : 1;
  localparam logic [XW-1:0] InvExp   = XW'((32'd1 << M) - 32'd2);
  localparam logic [CW-1:0] CntNorm  = CW'(EW - 1);
  localparam logic [CW-1:0] CntInv   = CW'(XW - 1);
  localparam logic [M-1:0]  One      = M'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [M-1:0]    x_q, x_d;
  logic [XW-1:0]   exp_q, exp_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [M-1:0]    acc_q, acc_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic            in_ready_q, in_ready_d;

  // Shift-and-add multiply, MSB of b first, reducing after every shift.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] r;
    r = '0;
    for (int i = M - 1; i >= 0; i--) begin
      r = {r[M-2:0], 1'b0} ^ (r[M-1] ? POLY[M-1:0] : '0);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  // Squaring over GF(2) only interleaves zeros; the reduction does the real work.
  function automatic logic [M-1:0] gf_sq(input logic [M-1:0] a);
    logic [2*M-2:0] p;
    p = '0;
    for (int i = 0; i < M; i++) p[2*i] = a[i];
    for (int k = 2 * M - 2; k >= M; k--) begin
      if (p[k]) p[k -: M+1] = p[k -: M+1] ^ POLY;
    end
    return p[M-1:0];
  endfunction

  logic [M-1:0] sq;
  logic [M-1:0] prod;
  logic [M-1:0] step;

  always_comb begin
    sq   = gf_sq(acc_q);
    prod = gf_mul(sq, x_q);
    step = exp_q[cnt_q] ? prod : sq;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready_q) begin
          x_d     = x;
          exp_d   = inv ? InvExp : XW'(e);
          cnt_d   = inv ? CntInv : CntNorm;
          acc_d   = One;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = step;
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Handshake flags are registered copies of the next state.
    out_valid_d = (state_d == StDone);
    busy_d      = (state_d != StIdle);
    in_ready_d  = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      x_q         <= '0;
      exp_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      exp_q       <= exp_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign y         = acc_q;

`ifndef SYNTHESIS
  a_hold_result: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid_q && !out_ready |=> out_valid_q && $stable(acc_q));
  a_ready_idle: assert property (@(posedge clk) disable iff (!rst_n)
    in_ready_q |-> !busy_q && !out_valid_q);
`endif

endmodule

// File: doc/gf_pow_seq.md
GF_POW_SEQ -- requirements
Module: gf_pow_seq

Interface
REQ-001 SHALL have parameter M, default 6: field degree in bits, legal range 2..16.
REQ-002 SHALL have parameter POLY, default 7'b1000011: reduction polynomial x^6+x+1, width M+1, bit M set, irreducible over GF(2).
REQ-003 SHALL have parameter EW, default 6: exponent width in bits, legal range 1..16.
REQ-004 clk  input  1  sole clock, all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  an operand is presented.
REQ-007 in_ready  output  1  block can accept an operand.
REQ-008 x  input  M  base element, polynomial basis, bit i is the coefficient of alpha^i.
REQ-009 e  input  EW  unsigned exponent.
REQ-010 inv  input  1  inverse mode: the block ignores e and uses exponent 2^M-2.
REQ-011 out_valid  output  1  result is valid.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 y  output  M  result x^e (or x^(2^M-2)), polynomial basis.
REQ-014 busy  output  1  high in RUN and DONE.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 SHALL drive in_ready=1 only in IDLE; SHALL accept an operand on an edge with in_valid&in_ready.
REQ-017 On accept, SHALL:
- latch x;
- latch the effective exponent, zero-extended to max(EW,M) bits when inv=1;
- set acc=1 and the bit counter to the exponent width minus 1;
- enter RUN.
REQ-018 RUN SHALL process one exponent bit per cycle, MSB first: acc <= acc^2 * (bit ? x : 1), with each product reduced mod POLY.
REQ-019 After the LSB is processed, SHALL enter DONE. out_valid SHALL rise exactly NB cycles after the accept edge, where NB = EW, or max(EW,M) in inv mode.
REQ-020 The squarer and multiplier SHALL be combinational GF(2^M) logic, with no lookup tables and a single-cycle path.
REQ-021 In DONE, SHALL hold out_valid=1 and y stable until an edge with out_ready=1, then return to IDLE.
REQ-022 in_ready SHALL be 0 in DONE. The next accept is possible at the earliest one cycle after the result handshake.
REQ-023 in_valid, x, e and inv SHALL be ignored outside IDLE. A change on them mid-operation SHALL NOT affect the result.
REQ-024 out_ready SHALL be ignored outside DONE.
REQ-025 Special values:
- e=0 SHALL give y=1 for every x, including 0^0=1.
- x=0 with e>0 SHALL give y=0.
- inv with x=0 SHALL give y=0.
REQ-026 y SHALL show the acc register at all times. y is meaningful only while out_valid=1.

Reset
REQ-027 rst_n low SHALL immediately force:
- state IDLE;
- acc, y, counter and latched operands to 0;
- out_valid=0 and busy=0.
REQ-028 in_ready SHALL be 0 while rst_n is low and SHALL be 1 on the first edge after release.
REQ-029 Reset asserted in RUN or DONE SHALL abort the operation with no result produced. The first post-reset accept SHALL behave as from power-up.

Verification
REQ-030 M=6, x=0x02, e=0x22, inv=0 -> out_valid NB=6 cycles after accept, y=0x24 (alpha^34).
REQ-031 x=0x02, e=6 -> y=0x03. Then x=0x02, e=63 -> y=0x01. Then x=0x00, e=0 -> y=0x01. Then x=0x00, e=5 -> y=0x00.
REQ-032 inv=1, x=0x02, e=0x15 (ignored) -> y=0x21 after 6 cycles. inv=1, x=0x00 -> y=0x00.
REQ-033 Backpressure: hold out_ready=0 for 10 cycles after out_valid, toggling x/e/in_valid -> y, out_valid and in_ready=0 stay stable; out_ready=1 -> IDLE the next cycle.
REQ-034 Drive rst_n low 3 cycles after accept (mid-RUN) -> out_valid=0, y=0 and busy=0 immediately. After release, x=0x02, e=7 -> y=0x06 with normal latency.
REQ-035 Random regression: for every x in 0..63 and random e, compare y against a software GF(2^6) model. Also run M=8, POLY=9'h11B, EW=8 with x=0x53, inv=1 -> y=0xCA.
